// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_hazard_pkg
// Description : Shared constants, consumer classes and stall predicate for the
//               hazard scoreboard. Optional feature macro: HAZARD_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_hazard_pkg;

  localparam int REG_ADDR_W       = 5;
  localparam int ALU_LAT_DEFAULT  = 1;
  localparam int LOAD_LAT_DEFAULT = 2;

  typedef enum logic [1:0] {
    CONS_EX,
    CONS_ID,
    CONS_MEM
  } cons_class_e;

  // EX consumers can take the MEM/WB forward, so only a countdown above 1 hurts.
  function automatic logic need_stall(input logic [1:0] rdy, input cons_class_e cls);
    logic r_need;
    r_need = 1'b0;
    case (cls)
      CONS_EX:  r_need = (rdy > 2'd1);
      CONS_ID:  r_need = (rdy != 2'd0);
      default:  r_need = 1'b0;
    endcase
    return r_need;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_entry.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sb_entry
// Description : Ready countdown and in-flight write count for one register.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_sb_entry
  import mips_hazard_pkg::*;
#(
  parameter int ALU_LAT  = ALU_LAT_DEFAULT,
  parameter int LOAD_LAT = LOAD_LAT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue,
  input  logic       is_load,
  input  logic       retire,
  output logic [1:0] rdy,
  output logic [1:0] inflt
);

  logic [1:0] r_rdy;
  logic [1:0] r_inflt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdy   <= 2'd0;
      r_inflt <= 2'd0;
    end else begin
      if (issue)
        r_rdy <= is_load ? 2'(LOAD_LAT) : 2'(ALU_LAT);
      else if (r_rdy != 2'd0)
        r_rdy <= r_rdy - 2'd1;

      if (issue && !retire)
        r_inflt <= r_inflt + 2'd1;
      else if (!issue && retire && (r_inflt != 2'd0))
        r_inflt <= r_inflt - 2'd1;
    end
  end

  // Pipeline depth bounds in-flight writes to three per register.
  always_ff @(posedge clk) begin
    if (reset && issue && !retire)
      assert (r_inflt != 2'd3);
  end

  assign rdy   = r_rdy;
  assign inflt = r_inflt;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : ID-stage stall generator tracking in-flight register writes.
//               Optional statistics outputs under macro HAZARD_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import mips_hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ALU_LAT  = ALU_LAT_DEFAULT,
  parameter int LOAD_LAT = LOAD_LAT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_early,
  input  logic                  id_rt_late,
  input  logic                  id_regwrite,
  input  logic [REG_ADDR_W-1:0] id_wraddr,
  input  logic                  id_is_load,
  input  logic                  id_flush,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_wraddr,
  output logic                  stall,
  output logic [NUM_REGS-1:0]   pending_mask
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [15:0]           load_use_events
`endif
);

  logic [NUM_REGS-1:0][1:0] w_rdy;
  logic [NUM_REGS-1:0][1:0] w_inflt;
  logic                     w_issue;
  logic                     w_retire;
  logic                     w_rs_haz;
  logic                     w_rt_haz;
  logic                     w_stall;
  cons_class_e              w_rs_cls;
  cons_class_e              w_rt_cls;

  assign w_rdy[0]   = 2'd0;
  assign w_inflt[0] = 2'd0;

  generate
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
      hazard_sb_entry #(
        .ALU_LAT  (ALU_LAT),
        .LOAD_LAT (LOAD_LAT)
      ) u_entry (
        .clk     (clk),
        .reset   (reset),
        .issue   (w_issue && (id_wraddr == REG_ADDR_W'(r))),
        .is_load (id_is_load),
        .retire  (w_retire && (wb_wraddr == REG_ADDR_W'(r))),
        .rdy     (w_rdy[r]),
        .inflt   (w_inflt[r])
      );
    end
  endgenerate

  // Branch/jump operands are needed in ID and override the store-data exemption.
  always_comb begin
    w_rs_cls = id_early ? CONS_ID : CONS_EX;
    w_rt_cls = id_early ? CONS_ID : (id_rt_late ? CONS_MEM : CONS_EX);
    w_rs_haz = id_uses_rs && (w_inflt[id_rs] != 2'd0) && need_stall(w_rdy[id_rs], w_rs_cls);
    w_rt_haz = id_uses_rt && (w_inflt[id_rt] != 2'd0) && need_stall(w_rdy[id_rt], w_rt_cls);
  end

  assign w_stall  = reset && id_valid && !id_flush && (w_rs_haz || w_rt_haz);
  assign w_issue  = id_valid && id_regwrite && (id_wraddr != '0) && !w_stall && !id_flush;
  assign w_retire = wb_regwrite && (wb_wraddr != '0);
  assign stall    = w_stall;

  always_comb begin
    pending_mask = '0;
    for (int r = 1; r < NUM_REGS; r++)
      pending_mask[r] = (w_inflt[r] != 2'd0);
  end

`ifdef HAZARD_STATS_EN
  logic [NUM_REGS-1:0] r_src_load;
  logic                r_stall_q;
  logic [31:0]         r_stall_cycles;
  logic [15:0]         r_load_use;
  logic                w_load_cause;

  assign w_load_cause = (w_rs_haz && r_src_load[id_rs]) || (w_rt_haz && r_src_load[id_rt]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_src_load     <= '0;
      r_stall_q      <= 1'b0;
      r_stall_cycles <= 32'd0;
      r_load_use     <= 16'd0;
    end else begin
      if (w_issue)
        r_src_load[id_wraddr] <= id_is_load;
      r_stall_q <= w_stall;
      if (w_stall)
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_stall && !r_stall_q && w_load_cause && (r_load_use != 16'hFFFF))
        r_load_use <= r_load_use + 16'd1;
    end
  end

  assign stall_cycles    = r_stall_cycles;
  assign load_use_events = r_load_use;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed self-checking bench for hazard_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  logic        clk;
  logic        reset;
  logic        id_valid, id_uses_rs, id_uses_rt, id_early, id_rt_late;
  logic        id_regwrite, id_is_load, id_flush, wb_regwrite;
  logic [4:0]  id_rs, id_rt, id_wraddr, wb_wraddr;
  logic        stall;
  logic [31:0] pending_mask;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] load_use_events;
`endif

  int tests = 0;
  int fails = 0;

  hazard_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_early     (id_early),
    .id_rt_late   (id_rt_late),
    .id_regwrite  (id_regwrite),
    .id_wraddr    (id_wraddr),
    .id_is_load   (id_is_load),
    .id_flush     (id_flush),
    .wb_regwrite  (wb_regwrite),
    .wb_wraddr    (wb_wraddr),
    .stall        (stall),
    .pending_mask (pending_mask)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles    (stall_cycles),
    .load_use_events (load_use_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic id_idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_early = 0; id_rt_late = 0; id_regwrite = 0; id_wraddr = 0;
    id_is_load = 0; id_flush = 0;
  endtask

  // rs, rt, uses_rs, uses_rt, early, rt_late, regwrite, wraddr, is_load
  task automatic id_op(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic early, input logic late,
                       input logic rw, input logic [4:0] wa, input logic ld);
    id_valid = 1; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_early = early; id_rt_late = late; id_regwrite = rw; id_wraddr = wa;
    id_is_load = ld; id_flush = 0;
  endtask

  task automatic wb(input logic rw, input logic [4:0] wa);
    wb_regwrite = rw; wb_wraddr = wa;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk); #1;
    wb(0, 0);
  endtask

  initial begin
    id_idle(); wb(0, 0); reset = 0;
    repeat (2) @(posedge clk); #1;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_pending", pending_mask, 32'd0);
    reset = 1;
    next();

    // ALU -> ALU dependency, retire three cycles after issue
    id_op(1, 2, 1, 1, 0, 0, 1, 3, 0);          sample(); check("alu_producer_stall", {31'd0, stall}, 32'd0); next();
    id_op(3, 4, 1, 1, 0, 0, 0, 0, 0);          sample(); check("alu_alu_stall", {31'd0, stall}, 32'd0);
    check("alu_pending", pending_mask, 32'h8); next();
    id_idle();                                 sample(); next();
    wb(1, 3);                                  sample(); check("alu_pending_wb", pending_mask, 32'h8); next();
    sample(); check("alu_retired", pending_mask, 32'h0); next();

    // Load-use: one stall, then the add issues
    id_op(1, 2, 1, 1, 0, 0, 1, 5, 1);          sample(); next();
    id_op(5, 2, 1, 1, 0, 0, 1, 6, 0);          sample(); check("load_use_stall1", {31'd0, stall}, 32'd1); next();
    sample(); check("load_use_stall2", {31'd0, stall}, 32'd0); next();
    id_idle(); wb(1, 5);                       sample(); check("load_use_pending", pending_mask, 32'h60); next();
    sample(); check("load_use_add_only", pending_mask, 32'h40); next();
    wb(1, 6);                                  sample(); next();

    // Load -> branch: two stalls
    id_op(1, 2, 1, 1, 0, 0, 1, 7, 1);          sample(); next();
    id_op(7, 0, 1, 1, 1, 0, 0, 0, 0);          sample(); check("ld_br_stall1", {31'd0, stall}, 32'd1); next();
    sample(); check("ld_br_stall2", {31'd0, stall}, 32'd1); next();
    wb(1, 7);                                  sample(); check("ld_br_stall3", {31'd0, stall}, 32'd0); next();
    id_idle();                                 sample(); check("ld_br_clean", pending_mask, 32'h0); next();

    // ALU -> branch: one stall
    id_op(1, 2, 1, 1, 0, 0, 1, 11, 0);         sample(); next();
    id_op(11, 0, 1, 1, 1, 0, 0, 0, 0);         sample(); check("alu_br_stall1", {31'd0, stall}, 32'd1); next();
    sample(); check("alu_br_stall2", {31'd0, stall}, 32'd0); next();
    id_idle(); wb(1, 11);                      sample(); next();

    // Store data from a load: no stall on rt_late, one stall via rs
    id_op(1, 2, 1, 1, 0, 0, 1, 8, 1);          sample(); next();
    id_op(1, 8, 1, 1, 0, 1, 0, 0, 0);          sample(); check("store_rt_late", {31'd0, stall}, 32'd0); next();
    id_idle();                                 sample(); next();
    wb(1, 8);                                  sample(); next();
    id_op(1, 2, 1, 1, 0, 0, 1, 8, 1);          sample(); next();
    id_op(8, 2, 1, 1, 0, 1, 0, 0, 0);          sample(); check("store_rs_stall1", {31'd0, stall}, 32'd1); next();
    sample(); check("store_rs_stall2", {31'd0, stall}, 32'd0); next();
    id_idle();                                 sample(); next();
    wb(1, 8);                                  sample(); next();
    sample(); check("store_clean", pending_mask, 32'h0); next();

    // Overlapping writes to $9
    id_op(1, 2, 1, 1, 0, 0, 1, 9, 0);          sample(); next();
    sample(); check("overlap_second_nostall", {31'd0, stall}, 32'd0); next();
    id_idle();                                 sample(); next();
    wb(1, 9);                                  sample(); next();
    wb(1, 9);                                  sample(); check("overlap_still_pending", pending_mask, 32'h200); next();
    sample(); check("overlap_retired", pending_mask, 32'h0); next();

    // Same-cycle issue and retire on $9
    id_op(1, 2, 1, 1, 0, 0, 1, 9, 0);          sample(); next();
    id_idle();                                 sample(); next();
    sample(); next();
    id_op(1, 2, 1, 1, 0, 0, 1, 9, 0); wb(1, 9); sample(); next();
    id_op(9, 0, 1, 0, 1, 0, 0, 0, 0);          sample(); check("same_cycle_pending", pending_mask, 32'h200);
    check("same_cycle_rdy_reload", {31'd0, stall}, 32'd1); next();
    id_idle(); wb(1, 9);                       sample(); next();
    sample(); check("same_cycle_clean", pending_mask, 32'h0); next();

    // Flush of a stalled jalr: no stall, no issue
    id_op(1, 2, 1, 1, 0, 0, 1, 12, 1);         sample(); next();
    id_op(12, 0, 1, 0, 1, 0, 1, 31, 0);        sample(); check("flush_pre_stall", {31'd0, stall}, 32'd1); next();
    id_flush = 1;                              sample(); check("flush_stall", {31'd0, stall}, 32'd0); next();
    id_idle();                                 sample(); check("flush_no_issue", pending_mask, 32'h1000); next();
    wb(1, 12);                                 sample(); next();

    // Register 0 is never tracked
    id_op(1, 2, 1, 1, 0, 0, 1, 0, 1);          sample(); next();
    id_op(0, 0, 1, 1, 1, 0, 0, 0, 0);          sample(); check("r0_no_stall", {31'd0, stall}, 32'd0);
    check("r0_no_pending", pending_mask, 32'h0); next();

`ifdef HAZARD_STATS_EN
    id_idle(); sample();
    check("stats_stall_cycles", stall_cycles, 32'd7);
    check("stats_load_use", {16'd0, load_use_events}, 32'd4);
    next();
`endif

    // Asynchronous reset in the middle of a stall
    id_op(1, 2, 1, 1, 0, 0, 1, 13, 1);         sample(); next();
    id_op(13, 2, 1, 1, 0, 0, 1, 14, 0);        sample(); check("rst_pre_stall", {31'd0, stall}, 32'd1);
    #2 reset = 0;
    #1 check("rst_async_stall", {31'd0, stall}, 32'd0);
    check("rst_async_pending", pending_mask, 32'h0);
`ifdef HAZARD_STATS_EN
    check("rst_stats", stall_cycles, 32'd0);
`endif
    next();
    reset = 1; id_idle();                      sample(); check("rst_release_pending", pending_mask, 32'h0); next();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
